// File: rtl/audioport_pkg.sv
// Shared audioport constants and types for the destination-side CDC receiver.
package audioport_pkg;

  localparam int unsigned CDC_RX_CHANNELS    = 2;
  localparam int unsigned CDC_RX_DATA_W      = 24;
  localparam int unsigned CDC_RX_SYNC_STAGES = 2;
  localparam int unsigned CDC_RX_DEPTH       = 4;

  typedef logic [CDC_RX_CHANNELS-1:0][CDC_RX_DATA_W-1:0] cdc_rx_sample_t;

  typedef enum logic {
    StIdle,
    StPending
  } cdc_rx_state_e;

endpackage

// File: rtl/cdc_bit_sync.sv
// Multi-stage flip-flop synchroniser; each bit is synchronised independently.
module cdc_bit_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] sync_d [STAGES];
  logic [WIDTH-1:0] sync_q [STAGES];

  always_comb begin
    sync_d[0] = d_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_rx_unit.sv
// Toggle-handshake CDC receiver: captures sample sets into a FIFO with valid/ready
// output, flags protocol overruns and synchronises a vector of level signals.
module cdc_rx_unit
  import audioport_pkg::*;
#(
  parameter int unsigned CHANNELS    = CDC_RX_CHANNELS,
  parameter int unsigned DATA_W      = CDC_RX_DATA_W,
  parameter int unsigned SYNC_STAGES = CDC_RX_SYNC_STAGES,
  parameter int unsigned DEPTH       = CDC_RX_DEPTH,
  parameter int unsigned BIT_W       = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_tgl_in,
  input  logic [CHANNELS*DATA_W-1:0]   data_in,
  output logic                         ack_tgl_out,
  input  logic [BIT_W-1:0]             bits_in,
  output logic [BIT_W-1:0]             bits_out,
  output logic [CHANNELS*DATA_W-1:0]   data_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [$clog2(DEPTH):0]       fill_out,
  output logic                         overrun_out
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned FillW = PtrW + 1;
  localparam int unsigned DataW = CHANNELS * DATA_W;

  logic             req_sync;
  logic             edge_q, edge_d;
  logic             req_event;
  cdc_rx_state_e    state_q, state_d;
  logic             ack_q, ack_d;
  logic             overrun_q, overrun_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [DataW-1:0] mem_q [DEPTH];
  logic [DataW-1:0] mem_d [DEPTH];
  logic             full, wr_en, pop;

  cdc_bit_sync #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (req_tgl_in),
    .q_out (req_sync)
  );

  cdc_bit_sync #(
    .WIDTH  (BIT_W),
    .STAGES (SYNC_STAGES)
  ) u_bits_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (bits_in),
    .q_out (bits_out)
  );

  assign req_event = req_sync ^ edge_q;
  // Fullness uses the pre-edge count so a same-cycle pop never frees room for a write.
  assign full      = (fill_q == FillW'(DEPTH));
  assign pop       = (fill_q != '0) && ready_in;

  always_comb begin
    state_d   = state_q;
    overrun_d = overrun_q;
    wr_en     = 1'b0;
    edge_d    = req_sync;
    case (state_q)
      StIdle: begin
        if (req_event) begin
          if (!full) wr_en = 1'b1;
          else       state_d = StPending;
        end
      end
      StPending: begin
        // A fresh request while one is still parked is dropped and flagged.
        if (req_event) overrun_d = 1'b1;
        if (!full) begin
          wr_en   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    ack_d    = wr_en ? ~ack_q : ack_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    fill_d   = fill_q + FillW'(wr_en) - FillW'(pop);
    mem_d    = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q    <= 1'b0;
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      edge_q    <= edge_d;
      state_q   <= state_d;
      ack_q     <= ack_d;
      overrun_q <= overrun_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      mem_q     <= mem_d;
    end
  end

  assign ack_tgl_out = ack_q;
  assign overrun_out = overrun_q;
  assign fill_out    = fill_q;
  assign valid_out   = (fill_q != '0);
  assign data_out    = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_cdc_rx_unit.sv
// Directed self-checking bench for cdc_rx_unit with default parameters.
module tb_cdc_rx_unit;
  import audioport_pkg::*;

  localparam int W  = CDC_RX_CHANNELS * CDC_RX_DATA_W;
  localparam int FW = $clog2(CDC_RX_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_tgl_in = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          ack_tgl_out;
  logic [0:0]    bits_in = '0;
  logic [0:0]    bits_out;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          ready_in = 1'b0;
  logic [FW-1:0] fill_out;
  logic          overrun_out;

  int errors = 0;
  int checks = 0;

  cdc_rx_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_tgl_in  (req_tgl_in),
    .data_in     (data_in),
    .ack_tgl_out (ack_tgl_out),
    .bits_in     (bits_in),
    .bits_out    (bits_out),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .fill_out    (fill_out),
    .overrun_out (overrun_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic cdc_rx_sample_t mk(input int i);
    cdc_rx_sample_t s;
    s[1] = 24'(i) ^ 24'hA50000;
    s[0] = 24'(i * 3) + 24'h000100;
    return s;
  endfunction

  task automatic do_reset();
    rst_n      = 1'b0;
    req_tgl_in = 1'b0;
    ready_in   = 1'b0;
    data_in    = '0;
    bits_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Toggles req with new data and waits (bounded) for the acknowledge toggle.
  task automatic send(input cdc_rx_sample_t v, output bit ok);
    logic prev;
    prev       = ack_tgl_out;
    data_in    = v;
    req_tgl_in = ~req_tgl_in;
    ok         = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ack_tgl_out !== prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if (ack_tgl_out !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_tgl_out); end
    checks++; if (fill_out !== '0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_out); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", data_out); end
    checks++; if (bits_out !== 1'b0) begin errors++; $display("FAIL reset_bits: got %b want 0", bits_out); end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun_out); end
  endtask

  task automatic test_single();
    do_reset();
    ready_in   = 1'b1;
    data_in    = 48'h123456ABCDEF;
    req_tgl_in = 1'b1;
    tick(); tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", valid_out); end
    tick();
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", valid_out); end
    checks++; if (data_out !== 48'h123456ABCDEF) begin errors++; $display("FAIL single_data: got %h want 123456abcdef", data_out); end
    checks++; if (ack_tgl_out !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", ack_tgl_out); end
    checks++; if (fill_out !== FW'(1)) begin errors++; $display("FAIL single_fill: got %0d want 1", fill_out); end
    tick();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_popped: got %b want 0", valid_out); end
  endtask

  task automatic test_backpressure();
    bit ok;
    cdc_rx_sample_t got [8];
    int n;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(mk(i), ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_ack%0d: got timeout want ack", i); end
    end
    checks++; if (fill_out !== FW'(4)) begin errors++; $display("FAIL bp_fill_full: got %0d want 4", fill_out); end
    data_in    = mk(5);
    req_tgl_in = ~req_tgl_in;
    repeat (6) tick();
    checks++; if (ack_tgl_out !== 1'b0) begin errors++; $display("FAIL bp_pending_noack: got %b want 0", ack_tgl_out); end
    checks++; if (fill_out !== FW'(4)) begin errors++; $display("FAIL bp_pending_fill: got %0d want 4", fill_out); end
    ready_in = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (valid_out) begin
        got[n] = data_out;
        n++;
      end
      tick();
    end
    checks++; if (n != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", n); end
    for (int k = 0; k < n && k < 5; k++) begin
      checks++;
      if (got[k] !== mk(k + 1)) begin
        errors++; $display("FAIL bp_order%0d: got %h want %h", k, got[k], mk(k + 1));
      end
    end
    checks++; if (ack_tgl_out !== 1'b1) begin errors++; $display("FAIL bp_ack5: got %b want 1", ack_tgl_out); end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL bp_no_overrun: got %b want 0", overrun_out); end
    checks++; if (fill_out !== '0) begin errors++; $display("FAIL bp_drained: got %0d want 0", fill_out); end
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(mk(i), ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovr_ack%0d: got timeout want ack", i); end
    end
    data_in    = mk(5);
    req_tgl_in = ~req_tgl_in;
    repeat (6) tick();
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL ovr_pending_clean: got %b want 0", overrun_out); end
    req_tgl_in = ~req_tgl_in;
    repeat (6) tick();
    checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun_out); end
    checks++; if (fill_out !== FW'(4)) begin errors++; $display("FAIL ovr_fill: got %0d want 4", fill_out); end
    ready_in = 1'b1;
    repeat (15) tick();
    checks++; if (fill_out !== '0) begin errors++; $display("FAIL ovr_drain: got %0d want 0", fill_out); end
    checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL ovr_reset_clear: got %b want 0", overrun_out); end
  endtask

  task automatic test_stream();
    cdc_rx_sample_t got [16];
    int n, sent, maxfill;
    logic prev_ack;
    do_reset();
    ready_in   = 1'b1;
    prev_ack   = ack_tgl_out;
    data_in    = mk(100);
    req_tgl_in = ~req_tgl_in;
    sent       = 1;
    n          = 0;
    maxfill    = 0;
    for (int c = 0; c < 400 && n < 3 * CDC_RX_DEPTH; c++) begin
      tick();
      if (int'(fill_out) > maxfill) maxfill = int'(fill_out);
      if (valid_out) begin
        if (n < 16) got[n] = data_out;
        n++;
      end
      if (ack_tgl_out !== prev_ack) begin
        prev_ack = ack_tgl_out;
        if (sent < 3 * CDC_RX_DEPTH) begin
          data_in    = mk(100 + sent);
          req_tgl_in = ~req_tgl_in;
          sent++;
        end
      end
    end
    checks++; if (n != 3 * CDC_RX_DEPTH) begin errors++; $display("FAIL stream_count: got %0d want %0d", n, 3 * CDC_RX_DEPTH); end
    for (int k = 0; k < n && k < 3 * CDC_RX_DEPTH; k++) begin
      checks++;
      if (got[k] !== mk(100 + k)) begin
        errors++; $display("FAIL stream_data%0d: got %h want %h", k, got[k], mk(100 + k));
      end
    end
    checks++; if (maxfill > 1) begin errors++; $display("FAIL stream_maxfill: got %0d want <=1", maxfill); end
  endtask

  task automatic test_bits();
    do_reset();
    bits_in = 1'b1;
    tick();
    checks++; if (bits_out !== 1'b0) begin errors++; $display("FAIL bits_edge1: got %b want 0", bits_out); end
    tick();
    checks++; if (bits_out !== 1'b1) begin errors++; $display("FAIL bits_edge2: got %b want 1", bits_out); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    bits_in  = 1'b1;
    ready_in = 1'b1;
    send(mk(7), ok);
    tick();
    ready_in = 1'b0;
    send(mk(8), ok);
    send(mk(9), ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_ack: got timeout want ack"); end
    checks++; if (fill_out !== FW'(2)) begin errors++; $display("FAIL mid_fill: got %0d want 2", fill_out); end
    checks++; if (ack_tgl_out !== 1'b1) begin errors++; $display("FAIL mid_ack_level: got %b want 1", ack_tgl_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid_out); end
    checks++; if (fill_out !== '0) begin errors++; $display("FAIL mid_fill0: got %0d want 0", fill_out); end
    checks++; if (ack_tgl_out !== 1'b0) begin errors++; $display("FAIL mid_ack0: got %b want 0", ack_tgl_out); end
    checks++; if (bits_out !== 1'b0) begin errors++; $display("FAIL mid_bits0: got %b want 0", bits_out); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL mid_data0: got %h want 0", data_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overrun();
    test_stream();
    test_bits();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
